// File: rtl/arm_dp_pkg.sv
// rtl/arm_dp_pkg.sv - shared datapath constants and clear-engine state type
package arm_dp_pkg;
   localparam int XZR_IDX    = 31;
   localparam int REG_DATA_W = 64;
   localparam int REG_SEL_W  = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;
endpackage

// File: rtl/arm_reg_clear_fsm.sv
// rtl/arm_reg_clear_fsm.sv - sequential sweep that zeroes one register per cycle
module arm_reg_clear_fsm
   import arm_dp_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int SEL_WIDTH = REG_SEL_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_req,
   output logic                 clear_busy,
   output logic                 clear_done,
   output logic                 clr_we,
   output logic [SEL_WIDTH-1:0] clr_idx
);

   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);
   localparam logic                 ONE_REG  = (NUM_REGS == 1);

   clr_state_t           state;
   logic [SEL_WIDTH-1:0] cnt;

   // IDLE waits for a request; CLEAR walks cnt from 0 to LAST_IDX, done marks the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               clear_done <= 1'b0;
               if (clear_req) begin
                  state      <= CLEAR;
                  cnt        <= '0;
                  clear_busy <= 1'b1;
                  clear_done <= ONE_REG;
               end
            end
            CLEAR: begin
               if (cnt == LAST_IDX) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  clear_busy <= 1'b0;
                  clear_done <= 1'b0;
               end else begin
                  cnt        <= cnt + 1'b1;
                  clear_done <= ((cnt + 1'b1) == LAST_IDX);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a new request while sweeping is simply not looked at in CLEAR
   assign clr_we  = (state == CLEAR);
   assign clr_idx = cnt;

endmodule

// File: rtl/arm_reg_file.sv
// rtl/arm_reg_file.sv - 2R1W register file with XZR and clear sweep; option ARM_REG_FILE_WRITE_BYPASS_EN
module arm_reg_file
   import arm_dp_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_W,
   parameter int NUM_REGS   = 32,
   parameter int SEL_WIDTH  = REG_SEL_W,
   parameter int ZERO_REG   = XZR_IDX
) (
   input  logic                  CLK,
   input  logic                  Reset_n,
   input  logic [SEL_WIDTH-1:0]  ReadSelect1,
   input  logic [SEL_WIDTH-1:0]  ReadSelect2,
   input  logic [SEL_WIDTH-1:0]  WriteSelect,
   input  logic                  RegWrite,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   input  logic                  ClearReq,
   output logic                  ClearBusy,
   output logic                  ClearDone
);

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];
   logic                  clr_we;
   logic [SEL_WIDTH-1:0]  clr_idx;
   logic [DATA_WIDTH-1:0] stored1;
   logic [DATA_WIDTH-1:0] stored2;

   // an index is backed by real storage only if in range and not XZR
   function automatic logic live_idx(input logic [SEL_WIDTH-1:0] s);
      return (32'(s) < NUM_REGS) && (32'(s) != ZERO_REG);
   endfunction

   arm_reg_clear_fsm #(
      .NUM_REGS  (NUM_REGS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_clear (
      .clk        (CLK),
      .rst_n      (Reset_n),
      .clear_req  (ClearReq),
      .clear_busy (ClearBusy),
      .clear_done (ClearDone),
      .clr_we     (clr_we),
      .clr_idx    (clr_idx)
   );

   // storage: port write first, sweep clear last so the clear wins on the swept index
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (RegWrite && live_idx(WriteSelect)) begin
            mem[WriteSelect] <= WriteData;
         end
         if (clr_we) begin
            mem[clr_idx] <= '0;
         end
      end
   end

   assign stored1 = live_idx(ReadSelect1) ? mem[ReadSelect1] : '0;
   assign stored2 = live_idx(ReadSelect2) ? mem[ReadSelect2] : '0;

`ifdef ARM_REG_FILE_WRITE_BYPASS_EN
   // forward the in-flight write so a same-cycle read sees the new value
   assign ReadData1 = (RegWrite && (ReadSelect1 == WriteSelect) && live_idx(ReadSelect1))
                      ? WriteData : stored1;
   assign ReadData2 = (RegWrite && (ReadSelect2 == WriteSelect) && live_idx(ReadSelect2))
                      ? WriteData : stored2;
`else
   assign ReadData1 = stored1;
   assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_arm_reg_file.sv
// tb/tb_arm_reg_file.sv - self-checking bench for arm_reg_file
module tb_arm_reg_file;

`ifdef ARM_REG_FILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [63:0] DV = 64'hDEAD_BEEF_0000_0001;

   logic        CLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic [4:0]  ReadSelect1 = '0;
   logic [4:0]  ReadSelect2 = '0;
   logic [4:0]  WriteSelect = '0;
   logic        RegWrite = 1'b0;
   logic [63:0] WriteData = '0;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;
   logic        ClearReq = 1'b0;
   logic        ClearBusy;
   logic        ClearDone;

   int          passed = 0;
   int          total = 0;
   logic [63:0] ref_mem [32];

   typedef struct {
      logic        we;
      logic [4:0]  ws;
      logic [63:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [63:0] e1;
      logic [63:0] e2;
   } vec_t;

   vec_t vecs [8];

   arm_reg_file dut (
      .CLK         (CLK),
      .Reset_n     (Reset_n),
      .ReadSelect1 (ReadSelect1),
      .ReadSelect2 (ReadSelect2),
      .WriteSelect (WriteSelect),
      .RegWrite    (RegWrite),
      .WriteData   (WriteData),
      .ReadData1   (ReadData1),
      .ReadData2   (ReadData2),
      .ClearReq    (ClearReq),
      .ClearBusy   (ClearBusy),
      .ClearDone   (ClearDone)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   function automatic logic [63:0] model_read(input logic [4:0] rs, input logic we,
                                              input logic [4:0] ws, input logic [63:0] wd);
      if (rs == 5'd31) return 64'd0;
      if (BYP && we && rs == ws) return wd;
      return ref_mem[rs];
   endfunction

   task automatic step(input logic we, input logic [4:0] ws, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input string tag);
      @(negedge CLK);
      RegWrite = we; WriteSelect = ws; WriteData = wd;
      ReadSelect1 = r1; ReadSelect2 = r2;
      #1;
      check({tag, " rd1"}, ReadData1, model_read(r1, we, ws, wd));
      check({tag, " rd2"}, ReadData2, model_read(r2, we, ws, wd));
      if (we && ws != 5'd31) ref_mem[ws] = wd;
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 32; i++) begin
         @(negedge CLK);
         RegWrite = 1'b0;
         ReadSelect1 = 5'(i);
         ReadSelect2 = 5'(31 - i);
         #1;
         check({tag, " rd1"}, ReadData1, model_read(5'(i), 1'b0, 5'd0, 64'd0));
         check({tag, " rd2"}, ReadData2, model_read(5'(31 - i), 1'b0, 5'd0, 64'd0));
      end
   endtask

   // mode 0: stray second request at cycle 3; mode 1: writes colliding with the sweep
   task automatic sweep(input int mode);
      int busy_n, done_n, done_at;
      busy_n = 0; done_n = 0; done_at = 0;
      @(negedge CLK);
      RegWrite = 1'b0;
      ClearReq = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         ClearReq = (mode == 0 && k == 3);
         RegWrite = 1'b0;
         if (ClearBusy) busy_n++;
         if (ClearDone) begin done_n++; done_at = k; end
         if (mode == 1) begin
            if (k == 11) begin RegWrite = 1'b1; WriteSelect = 5'd2;  WriteData = 64'hAA; end
            if (k == 12) begin RegWrite = 1'b1; WriteSelect = 5'd20; WriteData = 64'hBB; end
            if (k == 13) begin
               ReadSelect1 = 5'd20;
               #1;
               check("sweep x20 before reached", ReadData1, 64'hBB);
            end
            if (k == 14) begin RegWrite = 1'b1; WriteSelect = 5'd13; WriteData = 64'hCC; end
         end
      end
      RegWrite = 1'b0;
      ClearReq = 1'b0;
      check("sweep busy cycles", 64'(busy_n), 64'd32);
      check("sweep done pulses", 64'(done_n), 64'd1);
      check("sweep done cycle", 64'(done_at), 64'd32);
      for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
      if (mode == 1) ref_mem[2] = 64'hAA;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;

      vecs[0] = '{1'b1, 5'd5,  DV,       5'd0,  5'd5,  64'd0, BYP ? DV : 64'd0};
      vecs[1] = '{1'b0, 5'd0,  64'd0,    5'd5,  5'd5,  DV, DV};
      vecs[2] = '{1'b1, 5'd31, '1,       5'd31, 5'd5,  64'd0, DV};
      vecs[3] = '{1'b0, 5'd0,  64'd0,    5'd31, 5'd31, 64'd0, 64'd0};
      vecs[4] = '{1'b1, 5'd7,  64'h1234, 5'd7,  5'd5,  BYP ? 64'h1234 : 64'd0, DV};
      vecs[5] = '{1'b0, 5'd0,  64'd0,    5'd7,  5'd7,  64'h1234, 64'h1234};
      vecs[6] = '{1'b1, 5'd5,  64'h55,   5'd5,  5'd7,  BYP ? 64'h55 : DV, 64'h1234};
      vecs[7] = '{1'b0, 5'd0,  64'd0,    5'd5,  5'd0,  64'h55, 64'd0};

      #2;
      check("reset busy", 64'(ClearBusy), 64'd0);
      check("reset done", 64'(ClearDone), 64'd0);
      @(negedge CLK);
      Reset_n = 1'b1;
      read_all("reset");

      for (int v = 0; v < 8; v++) begin
         @(negedge CLK);
         RegWrite = vecs[v].we; WriteSelect = vecs[v].ws; WriteData = vecs[v].wd;
         ReadSelect1 = vecs[v].r1; ReadSelect2 = vecs[v].r2;
         #1;
         check($sformatf("vec%0d rd1", v), ReadData1, vecs[v].e1);
         check($sformatf("vec%0d rd2", v), ReadData2, vecs[v].e2);
         if (vecs[v].we && vecs[v].ws != 5'd31) ref_mem[vecs[v].ws] = vecs[v].wd;
      end

      for (int n = 0; n < 300; n++) begin
         logic       we_r;
         logic [4:0] ws_r, r1_r, r2_r;
         we_r = 1'($urandom_range(0, 1));
         ws_r = 5'($urandom_range(0, 31));
         r1_r = ($urandom_range(0, 3) == 0) ? ws_r : 5'($urandom_range(0, 31));
         r2_r = ($urandom_range(0, 3) == 0) ? ws_r : 5'($urandom_range(0, 31));
         step(we_r, ws_r, {$urandom, $urandom}, r1_r, r2_r, "rand");
      end

      for (int i = 0; i < 31; i++) step(1'b1, 5'(i), 64'(i), 5'(i), 5'd0, "fill");
      sweep(0);
      read_all("after sweep");

      step(1'b1, 5'd25, 64'h77, 5'd25, 5'd0, "prefill");
      sweep(1);
      read_all("after collide");

      step(1'b1, 5'd3,  64'h33,   5'd3,  5'd0, "pre abort");
      step(1'b1, 5'd30, 64'h3030, 5'd30, 5'd3, "pre abort");
      @(negedge CLK);
      RegWrite = 1'b0;
      ClearReq = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         ClearReq = 1'b0;
      end
      check("abort busy before reset", 64'(ClearBusy), 64'd1);
      #1 Reset_n = 1'b0;
      #1;
      check("abort busy", 64'(ClearBusy), 64'd0);
      check("abort done", 64'(ClearDone), 64'd0);
      for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
      read_all("abort");
      @(negedge CLK);
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("post abort busy", 64'(ClearBusy), 64'd0);
      end
      read_all("post abort");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/arm_reg_file.md
Name: arm_reg_file

Overview:
- Register file that consumes the three 5-bit selects (ReadSelect1, ReadSelect2, WriteSelect) produced by the datapath's register-location decode.
- Provides two combinational read ports and one clocked write port, all 64-bit.
- X31 is hard-wired to zero (XZR).
- A sequential clear engine zeroes the file one register per cycle on request, so the datapath can re-initialise without asserting reset.

Parameters:
- DATA_WIDTH, 64, width of each register and each data port.
- NUM_REGS, 32, number of architectural registers.
- SEL_WIDTH, 5, width of each select input; must satisfy 2**SEL_WIDTH >= NUM_REGS.
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- ReadSelect1  input  SEL_WIDTH  read port 1 register index.
- ReadSelect2  input  SEL_WIDTH  read port 2 register index.
- WriteSelect  input  SEL_WIDTH  write port register index.
- RegWrite  input  1  write enable for the write port.
- WriteData  input  DATA_WIDTH  data to write.
- ReadData1  output  DATA_WIDTH  contents of register ReadSelect1.
- ReadData2  output  DATA_WIDTH  contents of register ReadSelect2.
- ClearReq  input  1  one-cycle pulse that starts the clear sweep.
- ClearBusy  output  1  high while the sweep is running.
- ClearDone  output  1  one-cycle pulse on the final sweep cycle.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - all registers become 0; FSM goes to IDLE; sweep counter = 0.
  - ClearBusy = 0, ClearDone = 0.
  - ReadData1 and ReadData2 = 0, because the storage is 0.
- Reads:
  - Combinational, zero latency: ReadDataN = mem[ReadSelectN].
  - ReadSelectN == ZERO_REG reads 0.
  - ReadSelectN >= NUM_REGS reads 0.
- Writes:
  - On a CLK rising edge with RegWrite = 1, mem[WriteSelect] <= WriteData.
  - WriteSelect == ZERO_REG or >= NUM_REGS is ignored.
  - Without the bypass feature, a read of the register being written returns the old value in that cycle and the new value from the next cycle.
- FSM, two states:
  - IDLE: ClearBusy = 0. When ClearReq = 1, go to CLEAR with counter = 0.
  - CLEAR: ClearBusy = 1. Each cycle, mem[counter] <= 0 and counter increments.
  - When counter == NUM_REGS-1: ClearDone = 1 for that cycle, then return to IDLE. A sweep takes exactly NUM_REGS cycles.
- Collisions during CLEAR:
  - A RegWrite to a register the sweep has already passed (index < counter) takes effect normally.
  - A RegWrite to the register being cleared in that same cycle, or to any later register (index >= counter), takes effect on that edge but is zeroed again when the sweep reaches that index.
  - The net rule is: any write to index >= counter during the sweep is lost.
- ClearReq while ClearBusy is high is ignored; the sweep is not restarted.
- Reset asserted mid-sweep aborts the sweep immediately and returns to the IDLE reset state.
- Counter width: SEL_WIDTH bits; no wrap beyond NUM_REGS-1.

Optional Feature:
- Macro: ARM_REG_FILE_WRITE_BYPASS_EN.
- Defined:
  - if RegWrite = 1 and ReadSelectN == WriteSelect, and the index is not ZERO_REG, ReadDataN = WriteData in the same cycle (write-to-read forwarding).
  - during CLEAR, forwarding still applies to WriteData.
- Undefined: plain storage read, old value in the write cycle (as above).

Decomposition:
- Shared package arm_dp_pkg holds:
  - constants XZR_IDX = 31, REG_DATA_W = 64, REG_SEL_W = 5.
  - enum clr_state_t {IDLE, CLEAR}.
- One sub-module, arm_reg_clear_fsm: owns state, counter, ClearBusy and ClearDone, and outputs clr_we and clr_idx.
- Storage, read muxing and bypass stay in arm_reg_file.

Test Plan:
- Reset then read: deassert Reset_n, read X0..X31 -> all 0.
- Write then read: write X5 = 64'hDEAD_BEEF_0000_0001, read on the next cycle via both ports -> that value.
- Zero register: write X31 = 64'hFFFF_FFFF_FFFF_FFFF -> ReadData1 = 0 for select 31.
- Same-cycle read of a write: write X7 = 64'h1234 while ReadSelect1 = 7.
  - Without the macro -> old value 0, then 64'h1234 next cycle.
  - With the macro -> 64'h1234 in the same cycle.
- Full sweep: fill X0..X30 with their own index, pulse ClearReq.
  - ClearBusy is high for 32 cycles; ClearDone pulses on cycle 32; all registers then read 0.
  - A second ClearReq at cycle 3 is ignored.
- Sweep collisions and reset abort:
  - During a sweep at counter = 10, write X2 = 64'hAA and X20 = 64'hBB -> after done, X2 = 64'hAA and X20 = 0.
  - Assert Reset_n low at counter = 15 -> ClearBusy = 0 at once and all registers = 0.
